wb_wr_fifo: RTL
===============

Name: wb_wr_fifo

Overview:
- Write-direction companion to the user-space read buffer. Wishbone master writes to the user window (wbs_adr_i[14:12] == 3'b111) are queued in a DEPTH-entry FIFO and presented to the controller through a valid/ready stream.
- Writes stall (ack withheld) while the FIFO is full.
- Status to the arbiter signals that write data is pending.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- DATA_W, 32, data width; fixed at 32 for Wishbone.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  Wishbone write enable; only writes are accepted
- wbs_sel_i  in  4  byte enables, stored with the data
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  address; bits [14:12] decode the window, full address is stored
- wbs_ack_o  out  1  registered acknowledge, one-cycle pulse per accepted write
- abt_empty_n  out  1  to arbiter; 1 when at least one entry is queued
- Do_valid  out  1  head entry valid (equals abt_empty_n)
- Do  out  32  head data
- Do_adr  out  32  head address
- Do_sel  out  4  head byte enables
- brc_out_ready  in  1  controller consumes the head entry this cycle
- fifo_cnt  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst=1 at a clk edge):
  - wr_ptr, rd_ptr and count go to 0; wbs_ack_o goes to 0.
  - Result: Do_valid=0, abt_empty_n=0, fifo_cnt=0, Do/Do_adr/Do_sel=0.
  - Storage array is not reset.
  - Reset mid-transfer discards all queued entries and any pending ack.
- Decode: wr_hit = wbs_stb_i & wbs_cyc_i & wbs_we_i & (wbs_adr_i[14:12]==3'b111).
- Push:
  - push = wr_hit & ~full & ~wbs_ack_o, where full = (count==DEPTH) from registered state.
  - On push, {adr, sel, dat} is written at wr_ptr and wr_ptr advances.
  - wbs_ack_o=1 in the next cycle only. Write-to-ack latency is 1 cycle.
  - The ~wbs_ack_o term blocks a duplicate push while the master still holds stb in its ack cycle.
- Full stall: while full, wr_hit gets no ack. The master waits, and the push happens the cycle after space frees up.
- Reads and non-window addresses: never acked by this block and no state change.
- Pop:
  - pop = brc_out_ready & Do_valid. On pop, rd_ptr advances.
  - brc_out_ready while empty is ignored.
- Show-ahead output:
  - Do/Do_adr/Do_sel come combinationally from mem[rd_ptr] when count>0, and are forced to 0 when count==0.
  - New data is visible 1 cycle after its push edge.
- Count:
  - push only: +1. Pop only: -1. Both in the same cycle: unchanged (legal whenever 0<count<DEPTH).
  - At count==DEPTH a pop frees space, but a push is not taken that cycle because full is registered. The push happens the next cycle.
- Pointers: log2(DEPTH) bits, wrap naturally modulo DEPTH. full/empty come from count, not from pointer compare.
- No overflow or underflow is possible by construction; no error outputs.

Test Plan:
- Reset, then write 0xDEADBEEF to adr 0x3000_7000, sel=4'hF, cycle N:
  - wbs_ack_o=1 in cycle N+1 only.
  - In N+1: Do_valid=1, Do=0xDEADBEEF, Do_adr=0x3000_7000, fifo_cnt=1.
  - Hold brc_out_ready=1 in N+1: fifo_cnt=0 and Do_valid=0 in N+2.
- Fill with DEPTH=4 writes 0x11..0x44 and brc_out_ready=0:
  - fifo_cnt=4, 5th write (0x55) gets no ack.
  - Pulse brc_out_ready once: 0x55 is acked within 2 cycles.
  - Subsequent pops yield 0x22,0x33,0x44,0x55 in order.
- Write with adr 0x3000_1000 (bits[14:12]=001), or wbs_we_i=0 to a window address: no ack and fifo_cnt stays 0.
- Wrap: push and pop 10 entries (0x0..0x9) with brc_out_ready=1 continuously. Outputs appear in order 0x0..0x9, fifo_cnt never exceeds 1, and pointers wrap twice.
- Simultaneous push and pop at count=2: fifo_cnt stays 2, head advances to the next entry, and the new entry appears at the tail.
- Assert rst for 1 cycle with 3 entries queued and an ack pending: next cycle wbs_ack_o=0, fifo_cnt=0, Do_valid=0, Do=0.

Source files
------------

// File: rtl/wb_wr_fifo.sv
// wb_wr_fifo: queues Wishbone writes that land in the user window
// (adr[14:12] == 3'b111) and hands them to the controller as a
// show-ahead valid/ready stream. Writes stall (no ack) while full.
module wb_wr_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    input  logic [31:0]       wbs_adr_i,
    output logic              wbs_ack_o,
    output logic              abt_empty_n,
    output logic              Do_valid,
    output logic [DATA_W-1:0] Do,
    output logic [31:0]       Do_adr,
    output logic [3:0]        Do_sel,
    input  logic              brc_out_ready,
    output logic [CNT_W-1:0]  fifo_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [31:0]       adr;
        logic [3:0]        sel;
        logic [DATA_W-1:0] dat;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic   wr_hit;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    entry_t head;

    assign wr_hit = wbs_stb_i & wbs_cyc_i & wbs_we_i & (wbs_adr_i[14:12] == 3'b111);

    // full/empty come from the registered count, so a pop at DEPTH only
    // lets the stalled write in on the following cycle.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // The ~wbs_ack_o term stops a second push while the master still
    // holds stb during its ack cycle.
    assign push = wr_hit & ~full & ~wbs_ack_o;
    assign pop  = brc_out_ready & ~empty;

    assign head        = mem[rd_ptr];
    assign Do_valid    = ~empty;
    assign abt_empty_n = ~empty;
    assign Do          = empty ? '0 : head.dat;
    assign Do_adr      = empty ? '0 : head.adr;
    assign Do_sel      = empty ? '0 : head.sel;
    assign fifo_cnt    = count;

    // Pointers, occupancy and the one-cycle ack pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wbs_ack_o <= 1'b0;
        end else begin
            wbs_ack_o <= push;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write on push; the head is read combinationally above.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale entries are never
        // visible because the outputs are forced to zero while count == 0.
        if (push) begin
            mem[wr_ptr] <= '{adr: wbs_adr_i, sel: wbs_sel_i, dat: wbs_dat_i};
        end
    end

endmodule
